// File: rtl/qpi_write_arbiter.sv
// Round-robin arbiter feeding the QPI TX write channel; grant is combinational, the issue is registered one cycle later.
// Backpressure: almostfull or a full outstanding window withholds new grants; an already captured write still issues.
module qpi_write_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int HDR_WIDTH       = 61,
  parameter int DATA_WIDTH      = 512,
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic                          clk,
  input  logic                          resetb,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*HDR_WIDTH-1:0]  req_header,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          tx_wr_almostfull,
  output logic                          tx_wr_valid,
  output logic [HDR_WIDTH-1:0]          tx_wr_header,
  output logic [DATA_WIDTH-1:0]         tx_wr_data,
  input  logic                          wr_rsp_valid,
  output logic [7:0]                    outstanding,
  output logic                          rsp_underflow
);

  localparam int         PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      cand;
  logic [PTR_W-1:0]      win;
  logic                  hit;
  logic                  eligible;
  logic                  gnt_any;
  logic [NUM_REQ-1:0]    gnt_c;
  logic [HDR_WIDTH-1:0]  hdr_sel;
  logic [DATA_WIDTH-1:0] dat_sel;

  // A full window may still grant when a completion frees a slot in the same cycle.
  assign eligible = resetb && !tx_wr_almostfull &&
                    ((outstanding < MAX_OUT) || ((outstanding == MAX_OUT) && wr_rsp_valid));

  always_comb begin
    gnt_c = '0;
    win   = '0;
    cand  = '0;
    hit   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!hit && req[cand]) begin
        hit = 1'b1;
        win = cand;
      end
    end
    if (eligible && hit) gnt_c[win] = 1'b1;
  end

  assign grant   = gnt_c;
  assign gnt_any = |gnt_c;

  always_comb begin
    hdr_sel = '0;
    dat_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == PTR_W'(i)) begin
        hdr_sel = req_header[i*HDR_WIDTH +: HDR_WIDTH];
        dat_sel = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rr_ptr       <= '0;
      tx_wr_valid  <= 1'b0;
      tx_wr_header <= '0;
      tx_wr_data   <= '0;
    end else begin
      tx_wr_valid <= gnt_any;
      if (gnt_any) begin
        rr_ptr       <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        tx_wr_header <= hdr_sel;
        tx_wr_data   <= dat_sel;
      end
    end
  end

  // A completion racing a grant cancels out, even when the count is zero.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      outstanding   <= '0;
      rsp_underflow <= 1'b0;
    end else begin
      case ({gnt_any, wr_rsp_valid})
        2'b10: outstanding <= outstanding + 8'd1;
        2'b01: begin
          if (outstanding != 8'd0) outstanding <= outstanding - 8'd1;
          else                     rsp_underflow <= 1'b1;
        end
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_qpi_write_arbiter.sv
module tb_qpi_write_arbiter;
  localparam int HW = 61;
  localparam int DW = 512;

  logic            clk = 1'b0;
  logic            resetb;
  logic [2:0]      req;
  logic [3*HW-1:0] req_header;
  logic [3*DW-1:0] req_data;
  logic [2:0]      grant;
  logic            tx_wr_almostfull;
  logic            tx_wr_valid;
  logic [HW-1:0]   tx_wr_header;
  logic [DW-1:0]   tx_wr_data;
  logic            wr_rsp_valid;
  logic [7:0]      outstanding;
  logic            rsp_underflow;

  logic [2:0]  req_s;
  logic [23:0] hdr_s;
  logic [23:0] dat_s;
  logic [2:0]  grant_s;
  logic        valid_s;
  logic [7:0]  thdr_s;
  logic [7:0]  tdat_s;
  logic        rsp_s;
  logic [7:0]  out_s;
  logic        unf_s;

  logic [HW-1:0] exp_hdr [3];
  logic [DW-1:0] exp_dat [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  qpi_write_arbiter dut (
    .clk(clk), .resetb(resetb), .req(req), .req_header(req_header), .req_data(req_data),
    .grant(grant), .tx_wr_almostfull(tx_wr_almostfull), .tx_wr_valid(tx_wr_valid),
    .tx_wr_header(tx_wr_header), .tx_wr_data(tx_wr_data), .wr_rsp_valid(wr_rsp_valid),
    .outstanding(outstanding), .rsp_underflow(rsp_underflow)
  );

  qpi_write_arbiter #(.NUM_REQ(3), .HDR_WIDTH(8), .DATA_WIDTH(8), .MAX_OUTSTANDING(2)) dut_small (
    .clk(clk), .resetb(resetb), .req(req_s), .req_header(hdr_s), .req_data(dat_s),
    .grant(grant_s), .tx_wr_almostfull(1'b0), .tx_wr_valid(valid_s),
    .tx_wr_header(thdr_s), .tx_wr_data(tdat_s), .wr_rsp_valid(rsp_s),
    .outstanding(out_s), .rsp_underflow(unf_s)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      exp_hdr[i] = 61'h0ABC_0000 + 61'(i);
      exp_dat[i] = {16{32'hD000_0000 + 32'(i)}};
      req_header[i*HW +: HW] = exp_hdr[i];
      req_data[i*DW +: DW]   = exp_dat[i];
    end
    hdr_s = 24'h221100;
    dat_s = 24'h665544;
    resetb = 1'b0; req = 3'b111; tx_wr_almostfull = 1'b0; wr_rsp_valid = 1'b0;
    req_s = 3'b000; rsp_s = 1'b0;

    // Held in reset with all requests high
    step(); #1;
    chk("rst_grant", grant, 3'b000);
    chk("rst_valid", tx_wr_valid, 1'b0);
    chk("rst_hdr", tx_wr_header, 0);
    chk("rst_dat", tx_wr_data, 0);
    chk("rst_out", outstanding, 0);
    chk("rst_unf", rsp_underflow, 1'b0);

    // Rotation with all requesters active
    step(); resetb = 1'b1; #1;
    chk("rr_g0", grant, 3'b001);
    step(); #1;
    chk("rr_v0", tx_wr_valid, 1'b1); chk("rr_h0", tx_wr_header, exp_hdr[0]);
    chk("rr_o1", outstanding, 1);    chk("rr_g1", grant, 3'b010);
    step(); #1;
    chk("rr_v1", tx_wr_valid, 1'b1); chk("rr_h1", tx_wr_header, exp_hdr[1]);
    chk("rr_o2", outstanding, 2);    chk("rr_g2", grant, 3'b100);
    step(); #1;
    chk("rr_v2", tx_wr_valid, 1'b1); chk("rr_h2", tx_wr_header, exp_hdr[2]);
    chk("rr_o3", outstanding, 3);    chk("rr_g3", grant, 3'b001);
    step(); req = 3'b000; #1;
    chk("rr_v3", tx_wr_valid, 1'b1); chk("rr_o4", outstanding, 4);
    chk("idle_grant", grant, 3'b000);

    // Sparse requests from pointer 1
    step(); req = 3'b101; #1;
    chk("idle_valid", tx_wr_valid, 1'b0); chk("hold_hdr", tx_wr_header, exp_hdr[0]);
    chk("sp_g2", grant, 3'b100);
    step(); #1;
    chk("sp_h2", tx_wr_header, exp_hdr[2]); chk("sp_d2", tx_wr_data, exp_dat[2]);
    chk("sp_o5", outstanding, 5);           chk("sp_g0", grant, 3'b001);
    step(); req = 3'b000; #1;
    chk("sp_h0", tx_wr_header, exp_hdr[0]); chk("sp_d0", tx_wr_data, exp_dat[0]);
    chk("sp_o6", outstanding, 6);

    // Completion alone, then completion coinciding with a grant
    step(); wr_rsp_valid = 1'b1; #1;
    chk("rsp_pre", outstanding, 6);
    step(); req = 3'b010; #1;
    chk("rsp_dec", outstanding, 5); chk("both_g", grant, 3'b010);
    step(); req = 3'b000; wr_rsp_valid = 1'b0; #1;
    chk("both_hold", outstanding, 5); chk("both_v", tx_wr_valid, 1'b1);
    chk("both_h", tx_wr_header, exp_hdr[1]);

    // Almostfull after a grant
    step(); req = 3'b111; #1;
    chk("af_g", grant, 3'b100);
    step(); tx_wr_almostfull = 1'b1; #1;
    chk("af_blk", grant, 3'b000); chk("af_issue", tx_wr_valid, 1'b1);
    chk("af_h", tx_wr_header, exp_hdr[2]);
    step(); #1;
    chk("af_blk2", grant, 3'b000); chk("af_noval", tx_wr_valid, 1'b0);
    chk("af_o6", outstanding, 6);
    step(); tx_wr_almostfull = 1'b0; #1;
    chk("af_rel", grant, 3'b001);
    step(); #1;
    chk("af_o7", outstanding, 7); chk("af_g1", grant, 3'b010);

    // Reset pulse mid-stream
    step(); resetb = 1'b0; #1;
    chk("mid_grant", grant, 3'b000); chk("mid_valid", tx_wr_valid, 1'b0);
    chk("mid_hdr", tx_wr_header, 0); chk("mid_dat", tx_wr_data, 0);
    chk("mid_out", outstanding, 0);
    step(); resetb = 1'b1; req = 3'b110; #1;
    chk("post_g", grant, 3'b010);

    // Underflow
    step(); req = 3'b000; wr_rsp_valid = 1'b1; #1;
    chk("post_v", tx_wr_valid, 1'b1); chk("post_h", tx_wr_header, exp_hdr[1]);
    chk("post_o1", outstanding, 1);
    step(); #1;
    chk("unf_o0", outstanding, 0); chk("unf_pre", rsp_underflow, 1'b0);
    step(); wr_rsp_valid = 1'b0; #1;
    chk("unf_set", rsp_underflow, 1'b1); chk("unf_o", outstanding, 0);
    step(); #1;
    chk("unf_sticky", rsp_underflow, 1'b1);
    step(); resetb = 1'b0; #1;
    chk("unf_clr", rsp_underflow, 1'b0);
    step(); resetb = 1'b1; #1;

    // Outstanding window of 2
    step(); req_s = 3'b001; #1;
    chk("w_g1", grant_s, 3'b001);
    step(); #1;
    chk("w_g2", grant_s, 3'b001); chk("w_o1", out_s, 1);
    step(); #1;
    chk("w_full", grant_s, 3'b000); chk("w_o2", out_s, 2);
    step(); #1;
    chk("w_full2", grant_s, 3'b000);
    step(); rsp_s = 1'b1; #1;
    chk("w_free", grant_s, 3'b001);
    step(); rsp_s = 1'b0; #1;
    chk("w_after", grant_s, 3'b000); chk("w_o2b", out_s, 2);
    chk("w_valid", valid_s, 1'b1);   chk("w_hdr", thdr_s, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/qpi_write_arbiter.md
QPI_WRITE_ARBITER -- requirements
Module: qpi_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of write requesters (index 0 = frame_release clear path, 1 = frame writer, 2 = status writer).
REQ-002 SHALL have parameter HDR_WIDTH, default 61: TX header width.
REQ-003 SHALL have parameter DATA_WIDTH, default 512: TX write data width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 64: maximum unacknowledged writes, range 1..255.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 resetb  input  1  reset, asynchronous, active-low.
REQ-007 req  input  NUM_REQ  per-requester write request level; bit i held high while requester i has a pending write.
REQ-008 req_header  input  NUM_REQ*HDR_WIDTH  packed headers; slice i belongs to requester i.
REQ-009 req_data  input  NUM_REQ*DATA_WIDTH  packed write data; slice i belongs to requester i.
REQ-010 grant  output  NUM_REQ  one-hot, one-cycle grant pulse; requester i advances on grant[i].
REQ-011 tx_wr_almostfull  input  1  TX write channel backpressure.
REQ-012 tx_wr_valid  output  1  TX write issue strobe.
REQ-013 tx_wr_header  output  HDR_WIDTH  registered header of issued write.
REQ-014 tx_wr_data  output  DATA_WIDTH  registered data of issued write.
REQ-015 wr_rsp_valid  input  1  one write completion returned from QPI.
REQ-016 outstanding  output  8  current unacknowledged write count.
REQ-017 rsp_underflow  output  1  sticky error flag.

Function
REQ-018 Arbitration SHALL be combinational each cycle: eligible = (req != 0) and !tx_wr_almostfull and (outstanding + issuing_this_cycle_adjust < MAX_OUTSTANDING), where a grant is permitted only if outstanding < MAX_OUTSTANDING, or outstanding == MAX_OUTSTANDING and wr_rsp_valid is high that cycle.
REQ-019 When eligible, the winner SHALL be the first set req bit searching upward from rr_ptr, wrapping NUM_REQ-1 -> 0.
REQ-020 grant SHALL be zero when not eligible and SHALL never have more than one bit set.
REQ-021 On a grant to i, rr_ptr SHALL become i+1, wrapping to 0 after NUM_REQ-1; without a grant rr_ptr SHALL hold.
REQ-022 On a grant to i, tx_wr_header/tx_wr_data SHALL capture slice i and tx_wr_valid SHALL be high exactly the next cycle (latency 1 from grant).
REQ-023 tx_wr_valid SHALL be low in any cycle not following a grant; tx_wr_header/tx_wr_data SHALL hold last captured values when not valid.
REQ-024 At most one write SHALL be issued per cycle; back-to-back grants on consecutive cycles SHALL be permitted.
REQ-025 tx_wr_almostfull SHALL block new grants only; a write already captured SHALL still issue the following cycle.
REQ-026 outstanding SHALL increment on each grant, decrement on each wr_rsp_valid, and hold when both occur in the same cycle.
REQ-027 outstanding SHALL never exceed MAX_OUTSTANDING.
REQ-028 wr_rsp_valid with outstanding == 0 and no grant that cycle SHALL leave outstanding at 0 and set rsp_underflow, which stays high until reset.
REQ-029 A requester dropping req without a grant SHALL lose its turn with no state change.

Reset
REQ-030 resetb low SHALL asynchronously force grant = 0, tx_wr_valid = 0, tx_wr_header = 0, tx_wr_data = 0, outstanding = 0, rr_ptr = 0, rsp_underflow = 0.
REQ-031 While resetb is low, grant SHALL be 0 regardless of req.
REQ-032 Reset asserted mid-operation SHALL discard any captured-but-unissued write and all outstanding accounting; the first cycle after deassertion behaves as post-reset with rr_ptr = 0.

Verification
REQ-033 req=3'b111 held, almostfull=0, no responses -> grants 001,010,100,001 on consecutive cycles; tx_wr_valid high one cycle after each; outstanding 1,2,3,4.
REQ-034 req=3'b101, rr_ptr=1 -> grant 100 then 001; header/data on TX match slice 2 then slice 0.
REQ-035 MAX_OUTSTANDING=2, req=001 held, no responses -> two grants then grant=0; a single wr_rsp_valid -> exactly one further grant, outstanding stays 2.
REQ-036 grant and wr_rsp_valid in the same cycle with outstanding=5 -> outstanding stays 5.
REQ-037 wr_rsp_valid with outstanding=0 -> outstanding 0, rsp_underflow 1 until resetb low.
REQ-038 almostfull rises in the cycle after a grant -> that write still issues (tx_wr_valid=1), no further grants until almostfull falls; resetb pulsed low mid-stream -> all outputs 0 immediately, first post-reset grant goes to lowest set req bit.
